// File: rtl/lock_scheduler_pkg.sv
// Shared command/ack encodings and FSM state type for the accelerator lock scheduler.
package lock_scheduler_pkg;

   localparam int CMD_TYPE_L    = 0;
   localparam int CMD_TYPE_H    = 7;
   localparam int CMD_TYPE_BITS = CMD_TYPE_H - CMD_TYPE_L + 1;
   localparam int LOCK_ID_L     = 8;
   localparam int LOCK_ID_H     = 15;
   localparam int LOCK_ID_BITS  = LOCK_ID_H - LOCK_ID_L + 1;

   localparam logic [CMD_TYPE_BITS-1:0] CMD_LOCK_CODE   = 8'h04;
   localparam logic [CMD_TYPE_BITS-1:0] CMD_UNLOCK_CODE = 8'h05;
   localparam logic [7:0]               ACK_OK_CODE     = 8'h01;
   localparam logic [7:0]               ACK_REJECT_CODE = 8'h02;

   typedef enum logic [1:0] {
      LS_IDLE,
      LS_PROCESS,
      LS_SEND_ACK
   } lock_sched_state_t;

endpackage

// File: rtl/lock_scheduler_rr.sv
// Round-robin picker: first set request at or after base, wrapping modulo N.
module lock_rr_picker #(
   parameter  int N = 16,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] base_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   logic [N-1:0] rotated;
   logic [W-1:0] off;
   logic [W:0]   sum;

   // Rotate so that base lands at bit 0, priority-encode the lowest bit, then undo the rotation.
   always_comb begin
      rotated = N'({req_i, req_i} >> base_i);
      found_o = 1'b0;
      off     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            found_o = 1'b1;
            off     = W'(i);
         end
      end
      sum   = {1'b0, base_i} + {1'b0, off};
      idx_o = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
   end

endmodule

// File: rtl/lock_scheduler.sv
// Multi-lock scheduler: grants locks to accelerators, queues contenders and hands
// ownership round-robin to the next waiter on unlock.
module lock_scheduler
   import lock_scheduler_pkg::*;
#(
   parameter  int MAX_ACCS  = 16,
   parameter  int NUM_LOCKS = 8,
   localparam int ACC_BITS  = $clog2(MAX_ACCS),
   localparam int LID_BITS  = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [63:0]         inStream_TDATA,
   input  logic                inStream_TVALID,
   input  logic [ACC_BITS-1:0] inStream_TID,
   output logic                inStream_TREADY,
   output logic [63:0]         outStream_TDATA,
   output logic                outStream_TVALID,
   input  logic                outStream_TREADY,
   output logic [ACC_BITS-1:0] outStream_TDEST
);

   lock_sched_state_t state_q;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic [7:0]               out_code_q;
   logic [ACC_BITS-1:0]      out_dest_q;
   logic [ACC_BITS-1:0]      cmd_acc_q;
   logic [CMD_TYPE_BITS-1:0] cmd_type_q;
   logic [LOCK_ID_BITS-1:0]  cmd_lid_q;

   logic [NUM_LOCKS-1:0]                    locked_q, locked_d;
   logic [NUM_LOCKS-1:0][ACC_BITS-1:0]      owner_q, owner_d;
   logic [NUM_LOCKS-1:0][MAX_ACCS-1:0]      waiters_q, waiters_d;

   logic                lid_ok;
   logic [LID_BITS-1:0] lid;
   logic                cur_locked;
   logic [ACC_BITS-1:0] cur_owner;
   logic [MAX_ACCS-1:0] cur_waiters;
   logic [ACC_BITS-1:0] rr_base;
   logic                rr_found;
   logic [ACC_BITS-1:0] rr_idx;
   logic                dec_ack;
   logic [7:0]          dec_code;
   logic [ACC_BITS-1:0] dec_dest;
   logic                unused_tdata;

   assign unused_tdata = ^inStream_TDATA[63:LOCK_ID_H+1];

   // Range check uses the full lock-id field so aliases above NUM_LOCKS are rejected, not wrapped.
   assign lid_ok      = int'(cmd_lid_q) < NUM_LOCKS;
   assign lid         = cmd_lid_q[LID_BITS-1:0];
   assign cur_locked  = locked_q[lid];
   assign cur_owner   = owner_q[lid];
   assign cur_waiters = waiters_q[lid];
   assign rr_base     = (cur_owner == ACC_BITS'(MAX_ACCS - 1)) ? '0 : cur_owner + ACC_BITS'(1);

   lock_rr_picker #(.N(MAX_ACCS)) u_rr (
      .req_i   (cur_waiters),
      .base_i  (rr_base),
      .found_o (rr_found),
      .idx_o   (rr_idx)
   );

   // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latches form.
   always_comb begin
      dec_ack   = 1'b0;
      dec_code  = ACK_REJECT_CODE;
      dec_dest  = cmd_acc_q;
      locked_d  = locked_q;
      owner_d   = owner_q;
      waiters_d = waiters_q;
      if (state_q == LS_PROCESS) begin
         if (cmd_type_q == CMD_LOCK_CODE) begin
            if (!lid_ok) begin
               dec_ack = 1'b1;
            end else if (!cur_locked) begin
               locked_d[lid] = 1'b1;
               owner_d[lid]  = cmd_acc_q;
               dec_ack       = 1'b1;
               dec_code      = ACK_OK_CODE;
            end else if (cur_owner == cmd_acc_q) begin
               dec_ack = 1'b1;
            end else begin
               waiters_d[lid][cmd_acc_q] = 1'b1;
            end
         end else if (cmd_type_q == CMD_UNLOCK_CODE && lid_ok && cur_locked) begin
            if (cur_owner == cmd_acc_q) begin
               if (rr_found) begin
                  waiters_d[lid][rr_idx] = 1'b0;
                  owner_d[lid]           = rr_idx;
                  dec_ack                = 1'b1;
                  dec_code               = ACK_OK_CODE;
                  dec_dest               = rr_idx;
               end else begin
                  locked_d[lid] = 1'b0;
               end
            end else if (cur_waiters[cmd_acc_q]) begin
               waiters_d[lid][cmd_acc_q] = 1'b0;
            end
         end
      end
   end

   // NOTE: the lock table is architectural state held in flops, so it is cleared on reset like any register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         locked_q  <= '0;
         owner_q   <= '0;
         waiters_q <= '0;
      end else begin
         locked_q  <= locked_d;
         owner_q   <= owner_d;
         waiters_q <= waiters_d;
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= LS_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_dest_q  <= '0;
         cmd_acc_q   <= '0;
         cmd_type_q  <= '0;
         cmd_lid_q   <= '0;
      end else begin
         case (state_q)
            LS_IDLE: begin
               if (inStream_TVALID && in_ready_q) begin
                  cmd_acc_q  <= inStream_TID;
                  cmd_type_q <= inStream_TDATA[CMD_TYPE_H:CMD_TYPE_L];
                  cmd_lid_q  <= inStream_TDATA[LOCK_ID_H:LOCK_ID_L];
                  in_ready_q <= 1'b0;
                  state_q    <= LS_PROCESS;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            LS_PROCESS: begin
               if (dec_ack) begin
                  out_valid_q <= 1'b1;
                  out_code_q  <= dec_code;
                  out_dest_q  <= dec_dest;
                  state_q     <= LS_SEND_ACK;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= LS_IDLE;
               end
            end
            LS_SEND_ACK: begin
               if (outStream_TREADY) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= LS_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
               state_q     <= LS_IDLE;
            end
         endcase
      end
   end

   assign inStream_TREADY  = in_ready_q;
   assign outStream_TVALID = out_valid_q;
   assign outStream_TDATA  = {56'b0, out_code_q};
   assign outStream_TDEST  = out_dest_q;

   for (genvar l = 0; l < NUM_LOCKS; l++) begin : g_inv
      a_waiters_imply_locked: assert property (@(posedge clk) disable iff (!rstn)
         (waiters_q[l] != '0) |-> locked_q[l]);
      a_owner_not_waiting: assert property (@(posedge clk) disable iff (!rstn)
         waiters_q[l][owner_q[l]] == 1'b0);
   end

   a_valid_only_in_send: assert property (@(posedge clk) disable iff (!rstn)
      out_valid_q |-> (state_q == LS_SEND_ACK));

endmodule
